// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - command byte constants and decoder state type
package glitch_pkg;

    localparam logic [7:0] CMD_ESC    = 8'h00;
    localparam logic [7:0] CMD_RST    = 8'hFF;
    localparam logic [7:0] CMD_BRST   = 8'hFE;
    localparam logic [7:0] CMD_ARM    = 8'hFC;
    localparam logic [7:0] CMD_WIDTH  = 8'h10;
    localparam logic [7:0] CMD_PULSES = 8'h11;
    localparam logic [7:0] CMD_DELAY0 = 8'h20;
    localparam logic [7:0] CMD_DELAY1 = 8'h21;
    localparam logic [7:0] CMD_DELAY2 = 8'h22;
    localparam logic [7:0] CMD_DELAY3 = 8'h23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        ARG  = 2'd2,
        PASS = 2'd3
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
// Ports: clk, rst (sync active-high), flush (drops all entries),
//        push/din enqueue, pop dequeue, dout head entry, full, empty.
// A pop frees its slot in the same cycle, so push on a full FIFO
// succeeds when a pop happens alongside it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_pop;
    logic             do_push;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/glitch_cmd_decoder.sv
// rtl/glitch_cmd_decoder.sv - host command byte decoder with passthrough FIFO
// Ports: clk, rst (sync active-high); rx_data/rx_valid host byte stream;
//        pt_data/pt_valid/pt_ready buffered passthrough toward target UART;
//        cfg_width/cfg_pulses/cfg_delay glitch configuration;
//        soft_rst/board_rst_req/glitch_arm/cmd_err one-cycle strobes;
//        pt_overflow sticky drop flag.
module glitch_cmd_decoder
    import glitch_pkg::*;
#(
    parameter int PT_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  pt_data,
    output logic        pt_valid,
    input  logic        pt_ready,
    output logic [7:0]  cfg_width,
    output logic [7:0]  cfg_pulses,
    output logic [31:0] cfg_delay,
    output logic        soft_rst,
    output logic        board_rst_req,
    output logic        glitch_arm,
    output logic        cmd_err,
    output logic        pt_overflow
);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  sel_q, sel_d;
    logic [7:0]  width_q, width_d;
    logic [7:0]  pulses_q, pulses_d;
    logic [31:0] delay_q, delay_d;
    logic        ovf_q, ovf_d;
    logic        soft_q, soft_d;
    logic        brst_q, brst_d;
    logic        arm_q, arm_d;
    logic        err_q, err_d;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_flush;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;

    assign fifo_pop = pt_valid && pt_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (PT_DEPTH)
    ) u_pt_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (rx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head entry is gated so an empty FIFO presents 0 instead of stale data.
    assign pt_valid      = !fifo_empty;
    assign pt_data       = fifo_empty ? 8'h00 : fifo_dout;
    assign cfg_width     = width_q;
    assign cfg_pulses    = pulses_q;
    assign cfg_delay     = delay_q;
    assign soft_rst      = soft_q;
    assign board_rst_req = brst_q;
    assign glitch_arm    = arm_q;
    assign cmd_err       = err_q;
    assign pt_overflow   = ovf_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        width_d    = width_q;
        pulses_d   = pulses_q;
        delay_d    = delay_q;
        ovf_d      = ovf_q;
        soft_d     = 1'b0;
        brst_d     = 1'b0;
        arm_d      = 1'b0;
        err_d      = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == CMD_ESC) begin
                        state_d = CMD;
                    end else begin
                        state_d = PASS;
                        cnt_d   = rx_data;
                    end
                end
                CMD: begin
                    state_d = IDLE;
                    case (rx_data)
                        CMD_RST: begin
                            // Clear lands on the same edge that raises soft_rst.
                            soft_d     = 1'b1;
                            width_d    = 8'h00;
                            pulses_d   = 8'h00;
                            delay_d    = 32'h0;
                            ovf_d      = 1'b0;
                            fifo_flush = 1'b1;
                        end
                        CMD_BRST: brst_d = 1'b1;
                        CMD_ARM:  arm_d  = 1'b1;
                        CMD_WIDTH, CMD_PULSES,
                        CMD_DELAY0, CMD_DELAY1, CMD_DELAY2, CMD_DELAY3: begin
                            sel_d   = rx_data;
                            state_d = ARG;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                ARG: begin
                    state_d = IDLE;
                    case (sel_q)
                        CMD_WIDTH:  width_d        = rx_data;
                        CMD_PULSES: pulses_d       = rx_data;
                        CMD_DELAY0: delay_d[7:0]   = rx_data;
                        CMD_DELAY1: delay_d[15:8]  = rx_data;
                        CMD_DELAY2: delay_d[23:16] = rx_data;
                        CMD_DELAY3: delay_d[31:24] = rx_data;
                        default: ;
                    endcase
                end
                PASS: begin
                    // Dropped bytes still count toward the length prefix.
                    cnt_d     = cnt_q - 8'd1;
                    fifo_push = 1'b1;
                    if (fifo_full && !fifo_pop) ovf_d = 1'b1;
                    if (cnt_q == 8'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'h00;
            sel_q    <= 8'h00;
            width_q  <= 8'h00;
            pulses_q <= 8'h00;
            delay_q  <= 32'h0;
            ovf_q    <= 1'b0;
            soft_q   <= 1'b0;
            brst_q   <= 1'b0;
            arm_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            width_q  <= width_d;
            pulses_q <= pulses_d;
            delay_q  <= delay_d;
            ovf_q    <= ovf_d;
            soft_q   <= soft_d;
            brst_q   <= brst_d;
            arm_q    <= arm_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_glitch_cmd_decoder.sv
// tb/tb_glitch_cmd_decoder.sv - directed self-checking bench for glitch_cmd_decoder
module tb_glitch_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  pt_data;
    logic        pt_valid;
    logic        pt_ready = 1'b1;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_pulses;
    logic [31:0] cfg_delay;
    logic        soft_rst;
    logic        board_rst_req;
    logic        glitch_arm;
    logic        cmd_err;
    logic        pt_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] cap [$];

    always #5 clk = ~clk;

    glitch_cmd_decoder #(.PT_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .pt_data       (pt_data),
        .pt_valid      (pt_valid),
        .pt_ready      (pt_ready),
        .cfg_width     (cfg_width),
        .cfg_pulses    (cfg_pulses),
        .cfg_delay     (cfg_delay),
        .soft_rst      (soft_rst),
        .board_rst_req (board_rst_req),
        .glitch_arm    (glitch_arm),
        .cmd_err       (cmd_err),
        .pt_overflow   (pt_overflow)
    );

    // Handshake happens at the next posedge; inputs are stable from here to it.
    always @(negedge clk) begin
        if (pt_valid && pt_ready) cap.push_back(pt_data);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        n_checks++;
        if ({pt_valid, pt_data, cfg_width, cfg_pulses, cfg_delay} !== 57'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", {pt_valid, pt_data, cfg_width, cfg_pulses, cfg_delay});
        end
        n_checks++;
        if ({soft_rst, board_rst_req, glitch_arm, cmd_err, pt_overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000", {soft_rst, board_rst_req, glitch_arm, cmd_err, pt_overflow});
        end
    endtask

    task automatic test_width();
        logic [3:0] seen;
        seen = 4'b0;
        send(8'h00); seen |= {soft_rst, board_rst_req, glitch_arm, cmd_err};
        send(8'h10); seen |= {soft_rst, board_rst_req, glitch_arm, cmd_err};
        send(8'h02); seen |= {soft_rst, board_rst_req, glitch_arm, cmd_err};
        n_checks++;
        if (cfg_width !== 8'h02) begin
            n_fail++;
            $display("FAIL width_write: got %h required 02", cfg_width);
        end
        n_checks++;
        if (seen !== 4'b0) begin
            n_fail++;
            $display("FAIL width_no_strobe: got %b required 0000", seen);
        end
    endtask

    task automatic test_delay();
        send(8'h00); send(8'h20); send(8'hC8);
        n_checks++;
        if (cfg_delay !== 32'h000000C8) begin
            n_fail++;
            $display("FAIL delay_byte0: got %h required 000000C8", cfg_delay);
        end
        send(8'h00); send(8'h23); send(8'h01);
        n_checks++;
        if (cfg_delay !== 32'h010000C8) begin
            n_fail++;
            $display("FAIL delay_byte3: got %h required 010000C8", cfg_delay);
        end
        send(8'h00); send(8'h11); send(8'h03);
        n_checks++;
        if ({cfg_pulses, cfg_width} !== 16'h0302) begin
            n_fail++;
            $display("FAIL pulses_write: got %h required 0302", {cfg_pulses, cfg_width});
        end
    endtask

    task automatic test_strobes();
        send(8'h00); send(8'hFE);
        n_checks++;
        if ({soft_rst, board_rst_req, glitch_arm, cmd_err} !== 4'b0100) begin
            n_fail++;
            $display("FAIL brst_pulse: got %b required 0100", {soft_rst, board_rst_req, glitch_arm, cmd_err});
        end
        send(8'h00);
        n_checks++;
        if (board_rst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL brst_one_cycle: got %b required 0", board_rst_req);
        end
        send(8'hFC);
        n_checks++;
        if ({soft_rst, board_rst_req, glitch_arm, cmd_err} !== 4'b0010) begin
            n_fail++;
            $display("FAIL arm_pulse: got %b required 0010", {soft_rst, board_rst_req, glitch_arm, cmd_err});
        end
        tick(1);
        n_checks++;
        if (glitch_arm !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_one_cycle: got %b required 0", glitch_arm);
        end
        send(8'h00); send(8'h55);
        n_checks++;
        if ({soft_rst, board_rst_req, glitch_arm, cmd_err} !== 4'b0001) begin
            n_fail++;
            $display("FAIL err_pulse: got %b required 0001", {soft_rst, board_rst_req, glitch_arm, cmd_err});
        end
        send(8'h00);
        n_checks++;
        if (cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got %b required 0", cmd_err);
        end
        // FSM must be back in IDLE: the 0x00 above opened a command.
        send(8'h10); send(8'h07);
        n_checks++;
        if (cfg_width !== 8'h07 || pt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_to_idle: got width %h pt_valid %b required 07 0", cfg_width, pt_valid);
        end
    endtask

    task automatic test_passthrough();
        string msg;
        int    bad;
        msg = "Synchronized\r\n";
        bad = 0;
        pt_ready = 1'b1;
        cap.delete();
        send(8'h0E);
        for (int i = 0; i < 14; i++) begin
            send(msg[i]);
            if (i == 0) begin
                n_checks++;
                if (pt_valid !== 1'b1 || pt_data !== 8'h53) begin
                    n_fail++;
                    $display("FAIL pt_latency: got valid %b data %h required 1 53", pt_valid, pt_data);
                end
            end
        end
        tick(4);
        n_checks++;
        if (cap.size() != 14) begin
            n_fail++;
            $display("FAIL pt_count: got %0d required 14", cap.size());
        end else begin
            for (int i = 0; i < 14; i++) if (cap[i] !== msg[i]) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL pt_order: got %0d wrong bytes required 0", bad);
            end
        end
        send(8'h00); send(8'h11); send(8'h0A);
        n_checks++;
        if (cfg_pulses !== 8'h0A || pt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pt_then_cmd: got pulses %h pt_valid %b required 0A 0", cfg_pulses, pt_valid);
        end
    endtask

    task automatic test_overflow();
        int bad;
        bad = 0;
        pt_ready = 1'b0;
        send(8'h14);
        for (int i = 0; i < 20; i++) begin
            send(8'hA0 + 8'(i));
            if (i == 15) begin
                n_checks++;
                if (pt_overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_at_full: got %b required 0", pt_overflow);
                end
            end
            if (i == 16) begin
                n_checks++;
                if (pt_overflow !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_on_drop: got %b required 1", pt_overflow);
                end
            end
        end
        // Back in IDLE after the 20th byte, so this is a command, not data.
        send(8'h00); send(8'h10); send(8'h09);
        n_checks++;
        if (cfg_width !== 8'h09 || pt_data !== 8'hA0) begin
            n_fail++;
            $display("FAIL ovf_idle: got width %h head %h required 09 A0", cfg_width, pt_data);
        end
        cap.delete();
        pt_ready = 1'b1;
        tick(20);
        n_checks++;
        if (cap.size() != 16) begin
            n_fail++;
            $display("FAIL ovf_drain_count: got %0d required 16", cap.size());
        end else begin
            for (int i = 0; i < 16; i++) if (cap[i] !== 8'hA0 + 8'(i)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL ovf_drain_order: got %0d wrong bytes required 0", bad);
            end
        end
        n_checks++;
        if (pt_overflow !== 1'b1 || pt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf %b valid %b required 1 0", pt_overflow, pt_valid);
        end
    endtask

    task automatic test_soft_reset();
        pt_ready = 1'b0;
        send(8'h03); send(8'h01); send(8'h02); send(8'h03);
        n_checks++;
        if (pt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL srst_pre_fifo: got %b required 1", pt_valid);
        end
        send(8'h00); send(8'hFF);
        n_checks++;
        if (soft_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL srst_pulse: got %b required 1", soft_rst);
        end
        n_checks++;
        if ({cfg_width, cfg_pulses, cfg_delay, pt_overflow, pt_valid} !== 50'h0) begin
            n_fail++;
            $display("FAIL srst_clear: got %h required 0", {cfg_width, cfg_pulses, cfg_delay, pt_overflow, pt_valid});
        end
        tick(1);
        n_checks++;
        if (soft_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL srst_one_cycle: got %b required 0", soft_rst);
        end
        pt_ready = 1'b1;
    endtask

    task automatic test_rst_mid_pass();
        send(8'h00); send(8'h10); send(8'h05);
        send(8'h00); send(8'h21); send(8'h77);
        pt_ready = 1'b0;
        send(8'h05); send(8'h11); send(8'h22);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++;
        if ({cfg_width, cfg_pulses, cfg_delay, pt_overflow, pt_valid, pt_data} !== 58'h0) begin
            n_fail++;
            $display("FAIL rst_clear: got %h required 0", {cfg_width, cfg_pulses, cfg_delay, pt_overflow, pt_valid, pt_data});
        end
        send(8'h00); send(8'h10); send(8'h04);
        n_checks++;
        if (cfg_width !== 8'h04 || pt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_to_idle: got width %h pt_valid %b required 04 0", cfg_width, pt_valid);
        end
        pt_ready = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_width();
        test_delay();
        test_strobes();
        test_passthrough();
        test_overflow();
        test_soft_reset();
        test_rst_mid_pass();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
